// File: rtl/alu_seq.sv
// Accumulator ALU with registered results and a start/busy/done handshake.
// Opcodes 0-7 keep the legacy results; opcode 12 runs an iterative shift-add multiply.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             a_is_zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero_flag,
  output logic             carry_flag
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StMul  = 1'b1;

  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpAnd = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpLda = 4'd5;
  localparam logic [3:0] OpSub = 4'd8;
  localparam logic [3:0] OpOr  = 4'd9;
  localparam logic [3:0] OpShl = 4'd10;
  localparam logic [3:0] OpShr = 4'd11;
  localparam logic [3:0] OpMul = 4'd12;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_step;

  // Single-cycle result; anything not decoded passes a through.
  always_comb begin
    sum   = {1'b0, in_a} + {1'b0, in_b};
    diff  = {1'b0, in_a} - {1'b0, in_b};
    res   = in_a;
    res_c = 1'b0;
    case (opcode)
      OpAdd: begin res = sum[WIDTH-1:0]; res_c = sum[WIDTH]; end
      OpAnd: res = in_a & in_b;
      OpXor: res = in_a ^ in_b;
      OpLda: res = in_b;
      OpSub: begin res = diff[WIDTH-1:0]; res_c = diff[WIDTH]; end
      OpOr:  res = in_a | in_b;
      OpShl: begin res = {in_a[WIDTH-2:0], 1'b0}; res_c = in_a[WIDTH-1]; end
      OpShr: begin res = {1'b0, in_a[WIDTH-1:1]}; res_c = in_a[0]; end
      default: ;
    endcase
  end

  // Upper half accumulates, lower half holds the remaining multiplier bits.
  always_comb begin
    addend    = prod_q[0] ? mcand_q : '0;
    step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    prod_step = {step_sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    out_d   = out_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (opcode == OpMul) begin
            state_d = StMul;
            mcand_d = in_a;
            prod_d  = {{WIDTH{1'b0}}, in_b};
            cnt_d   = '0;
          end else begin
            out_d   = res;
            zero_d  = (res == '0);
            carry_d = res_c;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          out_d   = prod_step[WIDTH-1:0];
          zero_d  = (prod_step[WIDTH-1:0] == '0);
          carry_d = |prod_step[2*WIDTH-1:WIDTH];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign a_is_zero  = (in_a == '0);
  assign busy       = (state_q == StMul);
  assign done       = done_q;
  assign alu_out    = out_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;

endmodule
